// File: rtl/cordic_pkg.sv
// cordic_pkg: fixed-point phase constants and sequencing state shared by the CORDIC blocks.
package cordic_pkg;
    localparam int PHASE_W = 19;
    localparam int FRAC_W = 16;
    localparam logic signed [PHASE_W-1:0] PI_Q3_16 = 19'sh3243F;
    localparam logic signed [PHASE_W:0] TWO_PI_Q3_16 = 20'sh6487F;
    typedef enum logic {EMPTY, PRIMED} state_e;
endpackage

// File: rtl/phase_wrap.sv
// phase_wrap: combinational cur - prev, wrapped into [-pi, +pi] in (3,16) radians.
module phase_wrap
    import cordic_pkg::*;
(
    input  logic signed [PHASE_W-1:0] cur_i,
    input  logic signed [PHASE_W-1:0] prev_i,
    output logic signed [PHASE_W-1:0] diff_o
);
    localparam int DW = PHASE_W + 1;
    localparam logic signed [DW-1:0] PI_E = DW'(PI_Q3_16);
    logic signed [DW-1:0] d, w;
    assign d = DW'(cur_i) - DW'(prev_i);
    // Exactly +pi or -pi is left alone; only strict excursions are folded back.
    assign w = d > PI_E ? d - TWO_PI_Q3_16 : d < -PI_E ? d + TWO_PI_Q3_16 : d;
    assign diff_o = PHASE_W'(w);
endmodule

// File: rtl/cordic_phase_discriminator.sv
// cordic_phase_discriminator: wrapped phase difference of consecutive samples, averaged over 2^LOG2_AVG.
// Define PHASE_DISC_SQUELCH_EN to drop samples with in_mag < SQUELCH_THR and flag them on out_squelch.
module cordic_phase_discriminator
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int PHASE_WIDTH = 19,
    parameter int LOG2_AVG = 2,
    parameter logic [WIDTH-1:0] SQUELCH_THR = 16'h0100
) (
    input  logic                   in_clk,
    input  logic                   in_rst,
    input  logic                   in_clear,
    input  logic                   in_valid,
    input  logic [PHASE_WIDTH-1:0] in_phase,
    input  logic [WIDTH-1:0]       in_mag,
    output logic                   out_valid,
    output logic [PHASE_WIDTH-1:0] out_freq,
    output logic                   out_squelch
);
    localparam int AW = PHASE_WIDTH + LOG2_AVG;
    localparam int CW = LOG2_AVG > 0 ? LOG2_AVG : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_AVG) - 1);

    if (PHASE_WIDTH != PHASE_W) begin : g_bad_phase_width
        $error("PHASE_WIDTH must be %0d", PHASE_W);
    end
    if (LOG2_AVG < 0 || LOG2_AVG > 8) begin : g_bad_log2_avg
        $error("LOG2_AVG must be within 0..8");
    end

    state_e state_q, state_d;
    logic signed [PHASE_WIDTH-1:0] prev_q, prev_d, diff_q, diff_d, wrap_diff, freq_q, freq_d;
    logic signed [AW-1:0] acc_q, acc_d, sum;
    logic [CW-1:0] cnt_q, cnt_d;
    logic dv_q, dv_d, vld_q, vld_d;
    logic low_mag, kill, accept, fire;

`ifdef PHASE_DISC_SQUELCH_EN
    logic sq_q, sq_d;
    assign low_mag = in_valid && in_mag < SQUELCH_THR;
    assign sq_d = in_clear ? sq_q : in_valid ? low_mag : sq_q;
    always_ff @(posedge in_clk or negedge in_rst)
        if (!in_rst) sq_q <= 1'b0;
        else         sq_q <= sq_d;
    assign out_squelch = sq_q;
`else
    logic unused_mag;
    assign low_mag = 1'b0;
    assign unused_mag = ^{in_mag, SQUELCH_THR};
    assign out_squelch = 1'b0;
`endif

    phase_wrap u_wrap (
        .cur_i  (in_phase),
        .prev_i (prev_q),
        .diff_o (wrap_diff)
    );

    // A squelched sample behaves exactly like a flush, including squashing stage 1.
    assign kill = in_clear | low_mag;
    assign accept = in_valid & ~kill;

    always_comb begin
        state_d = kill ? EMPTY : accept ? PRIMED : state_q;
        prev_d = accept ? in_phase : prev_q;
        dv_d = accept && state_q == PRIMED;
        diff_d = dv_d ? wrap_diff : diff_q;
        sum = acc_q + AW'(diff_q);
        fire = !kill && dv_q && cnt_q == CNT_LAST;
        acc_d = (kill || fire) ? '0 : dv_q ? sum : acc_q;
        cnt_d = (kill || fire) ? '0 : dv_q ? cnt_q + 1'b1 : cnt_q;
        vld_d = fire;
        freq_d = fire ? PHASE_WIDTH'(sum >>> LOG2_AVG) : freq_q;
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q <= EMPTY;
            prev_q <= '0;
            diff_q <= '0;
            dv_q <= 1'b0;
            acc_q <= '0;
            cnt_q <= '0;
            vld_q <= 1'b0;
            freq_q <= '0;
        end else begin
            state_q <= state_d;
            prev_q <= prev_d;
            diff_q <= diff_d;
            dv_q <= dv_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            vld_q <= vld_d;
            freq_q <= freq_d;
        end
    end

    assign out_valid = vld_q;
    assign out_freq = freq_q;
endmodule

// File: tb/tb_cordic_phase_discriminator.sv
// tb_cordic_phase_discriminator: directed checks of LOG2_AVG=0 and LOG2_AVG=2 instances on a shared stream.
module tb_cordic_phase_discriminator;
`ifdef PHASE_DISC_SQUELCH_EN
    localparam bit SQ_EN = 1'b1;
`else
    localparam bit SQ_EN = 1'b0;
`endif
    logic clk, rst, clear, valid;
    logic [18:0] phase;
    logic [15:0] mag;
    logic a0_v, a0_sq, a2_v, a2_sq;
    logic [18:0] a0_f, a2_f;
    int n_cmp = 0, n_err = 0, a0_pulses = 0, a2_pulses = 0, p;

    cordic_phase_discriminator #(.LOG2_AVG(0)) u_a0 (
        .in_clk(clk), .in_rst(rst), .in_clear(clear), .in_valid(valid),
        .in_phase(phase), .in_mag(mag),
        .out_valid(a0_v), .out_freq(a0_f), .out_squelch(a0_sq)
    );
    cordic_phase_discriminator #(.LOG2_AVG(2)) u_a2 (
        .in_clk(clk), .in_rst(rst), .in_clear(clear), .in_valid(valid),
        .in_phase(phase), .in_mag(mag),
        .out_valid(a2_v), .out_freq(a2_f), .out_squelch(a2_sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (a0_v) a0_pulses++;
        if (a2_v) a2_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [18:0] ph, input logic [15:0] m, input int gap);
        valid = 1'b1;
        phase = ph;
        mag = m;
        @(negedge clk);
        valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic clr();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic pair(input string tag, input logic [18:0] pv, input logic [18:0] cu, input logic [18:0] exp);
        clr();
        send(pv, 16'h0200, 0);
        send(cu, 16'h0200, 0);
        @(negedge clk);
        check({tag, "_v"}, 32'(a0_v), 32'd1);
        check({tag, "_f"}, 32'(a0_f), 32'(exp));
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; valid = 1'b0; phase = '0; mag = 16'h0200;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            phase = 19'($urandom);
            @(negedge clk);
        end
        check("rst_a0_v", 32'(a0_v), 0);
        check("rst_a0_f", 32'(a0_f), 0);
        check("rst_a0_sq", 32'(a0_sq), 0);
        check("rst_a2_v", 32'(a2_v), 0);
        check("rst_a2_f", 32'(a2_f), 0);
        valid = 1'b0;
        rst = 1'b1;
        p = a0_pulses;
        repeat (5) @(negedge clk);
        check("idle_a0_pulses", 32'(a0_pulses - p), 0);

        send(19'h00000, 16'h0200, 0);
        check("a0_first_v", 32'(a0_v), 0);
        send(19'h01000, 16'h0200, 0);
        check("a0_lat1_v", 32'(a0_v), 0);
        send(19'h02000, 16'h0200, 0);
        check("a0_d1_v", 32'(a0_v), 1);
        check("a0_d1_f", 32'(a0_f), 32'h01000);
        @(negedge clk);
        check("a0_d2_v", 32'(a0_v), 1);
        check("a0_d2_f", 32'(a0_f), 32'h01000);
        @(negedge clk);
        check("a0_one_cycle_v", 32'(a0_v), 0);
        check("a0_hold_f", 32'(a0_f), 32'h01000);

        pair("wrap_neg", 19'h30000, 19'h50000, 19'h0487F);
        pair("wrap_pos", 19'h50000, 19'h30000, 19'h7B781);
        pair("exact_pi", 19'h00000, 19'h3243F, 19'h3243F);
        pair("exact_mpi", 19'h00000, 19'h4DBC1, 19'h4DBC1);
        pair("pi_plus1", 19'h00000, 19'h32440, 19'h4DBC1);

        clr();
        @(negedge clk);
        p = a2_pulses;
        send(19'h00000, 16'h0200, 0);
        send(19'h00400, 16'h0200, 1);
        send(19'h00900, 16'h0200, 3);
        send(19'h00C00, 16'h0200, 2);
        send(19'h01000, 16'h0200, 0);
        check("avg_lat1_v", 32'(a2_v), 0);
        @(negedge clk);
        check("avg_v", 32'(a2_v), 1);
        check("avg_f", 32'(a2_f), 32'h00400);
        @(negedge clk);
        check("avg_pulses", 32'(a2_pulses - p), 1);

        clr();
        send(19'h00000, 16'h0200, 0);
        send(19'h01000, 16'h0200, 0);
        send(19'h02000, 16'h0200, 0);
        clear = 1'b1;
        valid = 1'b1;
        phase = 19'h05000;
        p = a2_pulses;
        @(negedge clk);
        clear = 1'b0;
        valid = 1'b0;
        check("clr_hold_f", 32'(a2_f), 32'h00400);
        check("clr_v", 32'(a2_v), 0);
        send(19'h10000, 16'h0200, 0);
        send(19'h10100, 16'h0200, 0);
        send(19'h10300, 16'h0200, 0);
        send(19'h10400, 16'h0200, 0);
        send(19'h10800, 16'h0200, 0);
        check("clr_early_pulses", 32'(a2_pulses - p), 0);
        @(negedge clk);
        check("clr_out_v", 32'(a2_v), 1);
        check("clr_out_f", 32'(a2_f), 32'h00200);

        clr();
        @(negedge clk);
        p = a2_pulses;
        send(19'h00000, 16'h0200, 0);
        send(19'h00100, 16'h0200, 0);
        send(19'h00200, 16'h0200, 0);
        send(19'h00300, 16'h00FF, 0);
        check("sq_set", 32'(a2_sq), 32'(SQ_EN));
        send(19'h01000, 16'h0200, 2);
        check("sq_release", 32'(a2_sq), 0);
        check("sq_pulses", 32'(a2_pulses - p), SQ_EN ? 0 : 1);
        check("sq_f", 32'(a2_f), SQ_EN ? 32'h00200 : 32'h00400);
        send(19'h01100, 16'h0200, 0);
        send(19'h01200, 16'h0200, 0);
        send(19'h01300, 16'h0200, 0);
        send(19'h01400, 16'h0200, 0);
        @(negedge clk);
        check("sq_next_v", 32'(a2_v), 1);
        check("sq_next_f", 32'(a2_f), 32'h00100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
